// File: rtl/hsv_core_flush_responder_if.sv
// rtl/hsv_core_flush_responder_if.sv - flush handshake and pipeline control bundle
interface hsv_core_flush_responder_if #(
    parameter int NUM_STAGES = 4
);
    logic                  flush_req;
    logic [31:0]           flush_target;
    logic                  flush_ack;
    logic [NUM_STAGES-1:0] stage_flush;
    logic [NUM_STAGES-1:0] stage_idle;
    logic                  fetch_redirect;
    logic [31:0]           fetch_target;

    // Responder side: the flush block itself.
    modport slave (
        input  flush_req,
        input  flush_target,
        input  stage_idle,
        output flush_ack,
        output stage_flush,
        output fetch_redirect,
        output fetch_target
    );

    // Environment side: initiator FSM, pipeline stages and fetch unit.
    modport master (
        output flush_req,
        output flush_target,
        output stage_idle,
        input  flush_ack,
        input  stage_flush,
        input  fetch_redirect,
        input  fetch_target
    );
endinterface

// File: rtl/hsv_core_flush_responder.sv
// rtl/hsv_core_flush_responder.sv - four-phase core flush responder with drain, redirect and hold
module hsv_core_flush_responder #(
    parameter int NUM_STAGES       = 4,
    parameter int MIN_FLUSH_CYCLES = 2
) (
    input  logic                         clk_core,
    input  logic                         rst_core,
    hsv_core_flush_responder_if.slave    flush_if,
    output logic                         flush_busy,
    output logic [31:0]                  flush_count
);

    generate
        if (MIN_FLUSH_CYCLES < 1) begin : g_bad_min_flush
            $error("MIN_FLUSH_CYCLES must be 1 or more");
        end
    endgenerate

    localparam int CNT_W = $clog2(MIN_FLUSH_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MIN_FLUSH_CYCLES - 1);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_DRAIN    = 3'd1;
    localparam logic [2:0] ST_REDIRECT = 3'd2;
    localparam logic [2:0] ST_ACK      = 3'd3;
    localparam logic [2:0] ST_RELEASE  = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      target_q, target_d;
    logic [31:0]      count_q, count_d;

    logic all_idle;
    assign all_idle = &flush_if.stage_idle;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        target_d = target_q;
        count_d  = count_q;
        case (state_q)
            ST_IDLE: begin
                if (flush_if.flush_req) begin
                    state_d = ST_DRAIN;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_DRAIN: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end
                // Target is sampled here rather than at request time: the
                // initiator registers flush_target one cycle after flush_req.
                if ((cnt_q == '0) && all_idle) begin
                    state_d  = ST_REDIRECT;
                    target_d = flush_if.flush_target;
                end
            end
            ST_REDIRECT: begin
                state_d = ST_ACK;
                count_d = count_q + 32'd1;
            end
            ST_ACK: begin
                // Hold the pipeline empty for as long as the initiator wants,
                // e.g. across wait-for-interrupt.
                if (!flush_if.flush_req) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                // Request is ignored here so a re-raised request is seen
                // fresh from IDLE.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_core) begin
        if (rst_core) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            target_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            target_q <= target_d;
            count_q  <= count_d;
        end
    end

    logic hold_pipe;
    assign hold_pipe = (state_q == ST_DRAIN) || (state_q == ST_REDIRECT) || (state_q == ST_ACK);

    assign flush_if.stage_flush    = {NUM_STAGES{hold_pipe}};
    assign flush_if.fetch_redirect = (state_q == ST_REDIRECT);
    assign flush_if.fetch_target   = target_q;
    assign flush_if.flush_ack      = (state_q == ST_ACK);
    assign flush_busy              = (state_q != ST_IDLE);
    assign flush_count             = count_q;

endmodule

// File: tb/tb_hsv_core_flush_responder.sv
// tb/tb_hsv_core_flush_responder.sv - directed table-driven bench for the flush responder
module tb_hsv_core_flush_responder;

    logic        clk_core;
    logic        rst_core;
    logic        flush_busy;
    logic [31:0] flush_count;

    hsv_core_flush_responder_if #(.NUM_STAGES(4)) bus ();

    hsv_core_flush_responder #(
        .NUM_STAGES       (4),
        .MIN_FLUSH_CYCLES (2)
    ) dut (
        .clk_core    (clk_core),
        .rst_core    (rst_core),
        .flush_if    (bus),
        .flush_busy  (flush_busy),
        .flush_count (flush_count)
    );

    initial clk_core = 1'b0;
    always #5 clk_core = ~clk_core;

    typedef struct {
        logic        rst;
        logic        req;
        logic [31:0] tgt;
        logic [3:0]  idle;
        logic        ack;
        logic        fl;
        logic        rd;
        logic [31:0] ft;
        logic        busy;
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs[$];
    int   tests_run;
    int   tests_failed;

    task automatic add(input logic rst, input logic req, input logic [31:0] tgt,
                       input logic [3:0] idle, input logic ack, input logic fl,
                       input logic rd, input logic [31:0] ft, input logic busy,
                       input logic [31:0] cnt);
        vec_t v;
        v.rst = rst; v.req = req; v.tgt = tgt; v.idle = idle;
        v.ack = ack; v.fl = fl; v.rd = rd; v.ft = ft; v.busy = busy; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic ack, input logic fl, input logic rd,
                             input logic [31:0] ft, input logic busy, input logic [31:0] cnt);
        check({tag, ".ack"},   {31'd0, bus.flush_ack}, {31'd0, ack});
        check({tag, ".flush"}, {28'd0, bus.stage_flush}, fl ? 32'hF : 32'h0);
        check({tag, ".redir"}, {31'd0, bus.fetch_redirect}, {31'd0, rd});
        check({tag, ".ftgt"},  bus.fetch_target, ft);
        check({tag, ".busy"},  {31'd0, flush_busy}, {31'd0, busy});
        check({tag, ".count"}, flush_count, cnt);
    endtask

    task automatic step();
        @(posedge clk_core);
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_core         = 1'b1;
        bus.flush_req    = 1'b0;
        bus.flush_target = 32'h0;
        bus.stage_idle   = 4'hF;
        repeat (2) @(posedge clk_core);
        #1;
        rst_core = 1'b0;

        // rst req target      idle  | ack fl rd ft          busy cnt
        // Basic handshake, ack held 2 cycles before req drops
        add(0, 1, 32'hBAD0_0000, 4'hF, 0, 0, 0, 32'h0,   0, 0);
        add(0, 1, 32'h0000_0100, 4'hF, 0, 1, 0, 32'h0,   1, 0);
        add(0, 1, 32'h0000_0100, 4'hF, 0, 1, 0, 32'h0,   1, 0);
        add(0, 1, 32'h0000_0100, 4'hF, 0, 1, 1, 32'h100, 1, 0);
        add(0, 1, 32'h0000_0100, 4'hF, 1, 1, 0, 32'h100, 1, 1);
        add(0, 1, 32'h0000_0100, 4'hF, 1, 1, 0, 32'h100, 1, 1);
        add(0, 0, 32'h0000_0100, 4'hF, 1, 1, 0, 32'h100, 1, 1);
        // Back-to-back: re-raised in RELEASE, accepted from IDLE
        add(0, 1, 32'h0000_0200, 4'hF, 0, 0, 0, 32'h100, 1, 1);
        add(0, 1, 32'h0000_0200, 4'hF, 0, 0, 0, 32'h100, 0, 1);
        add(0, 1, 32'h0000_0200, 4'hF, 0, 1, 0, 32'h100, 1, 1);
        add(0, 1, 32'h0000_0200, 4'hF, 0, 1, 0, 32'h100, 1, 1);
        add(0, 1, 32'h0000_0200, 4'hF, 0, 1, 1, 32'h200, 1, 1);
        add(0, 0, 32'h0000_0200, 4'hF, 1, 1, 0, 32'h200, 1, 2);
        add(0, 0, 32'h0000_0200, 4'hF, 0, 0, 0, 32'h200, 1, 2);
        add(0, 0, 32'h0000_0200, 4'hF, 0, 0, 0, 32'h200, 0, 2);
        // Early request drop right after DRAIN entry; counter runs while not idle
        add(0, 1, 32'h0000_0300, 4'hF, 0, 0, 0, 32'h200, 0, 2);
        add(0, 1, 32'h0000_0300, 4'h0, 0, 1, 0, 32'h200, 1, 2);
        add(0, 0, 32'h0000_0300, 4'hF, 0, 1, 0, 32'h200, 1, 2);
        add(0, 0, 32'h0000_0300, 4'hF, 0, 1, 1, 32'h300, 1, 2);
        add(0, 0, 32'h0000_0300, 4'hF, 1, 1, 0, 32'h300, 1, 3);
        add(0, 0, 32'h0000_0300, 4'hF, 0, 0, 0, 32'h300, 1, 3);
        add(0, 0, 32'h0000_0300, 4'hF, 0, 0, 0, 32'h300, 0, 3);

        for (int i = 0; i < vecs.size(); i++) begin
            rst_core         = vecs[i].rst;
            bus.flush_req    = vecs[i].req;
            bus.flush_target = vecs[i].tgt;
            bus.stage_idle   = vecs[i].idle;
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].ack, vecs[i].fl, vecs[i].rd,
                      vecs[i].ft, vecs[i].busy, vecs[i].cnt);
            step();
        end

        // Slow drain: one stage busy until cycle 10, redirect at cycle 11
        for (int c = 0; c <= 11; c++) begin
            bus.flush_req    = 1'b1;
            bus.flush_target = (c == 0) ? 32'hBAD0_0001 : 32'h0000_0400;
            bus.stage_idle   = (c >= 10) ? 4'hF : 4'h7;
            #1;
            if (c >= 1) begin
                check($sformatf("slow%0d.flush", c), {28'd0, bus.stage_flush}, 32'hF);
                check($sformatf("slow%0d.redir", c), {31'd0, bus.fetch_redirect},
                      (c == 11) ? 32'd1 : 32'd0);
            end
            step();
        end

        // Long hold: 100 cycles in ACK, single redirect and single count
        for (int h = 0; h < 100; h++) begin
            #1;
            check_all($sformatf("hold%0d", h), 1'b1, 1'b1, 1'b0, 32'h400, 1'b1, 32'd4);
            step();
        end
        bus.flush_req = 1'b0;
        #1;
        check_all("hold_drop", 1'b1, 1'b1, 1'b0, 32'h400, 1'b1, 32'd4);
        step();
        check_all("hold_release", 1'b0, 1'b0, 1'b0, 32'h400, 1'b1, 32'd4);
        step();
        check_all("hold_idle", 1'b0, 1'b0, 1'b0, 32'h400, 1'b0, 32'd4);

        // Reset while in ACK
        bus.flush_req    = 1'b1;
        bus.flush_target = 32'h0000_0500;
        begin
            bit seen_ack;
            seen_ack = 1'b0;
            for (int w = 0; w < 20; w++) begin
                #1;
                if (bus.flush_ack) begin
                    seen_ack = 1'b1;
                    break;
                end
                step();
            end
            check("rst_wait_ack", {31'd0, seen_ack}, 32'd1);
        end
        rst_core = 1'b1;
        step();
        rst_core      = 1'b0;
        bus.flush_req = 1'b0;
        #1;
        check_all("rst_ack", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'd0);
        step();
        check_all("rst_idle", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/hsv_core_flush_responder.md
Name: hsv_core_flush_responder

Overview:
- Responder end of the core flush handshake.
- Accepts the four-phase flush_req/flush_ack protocol from the control/status FSM.
- Drives per-stage flush lines, waits for the pipeline to drain, redirects fetch to flush_target, then acknowledges.
- Keeps the pipeline held empty until the initiator drops its request. This covers long holds such as wait-for-interrupt.

Parameters:
- NUM_STAGES, 4, number of pipeline stages flushed; width of the stage_flush and stage_idle vectors.
- MIN_FLUSH_CYCLES, 2, minimum number of DRAIN cycles; legal range is 1 or more.

Ports:
- clk_core  in  1  core clock
- rst_core  in  1  synchronous, active-high reset
- flush_req  in  1  flush request from the initiator; four-phase
- flush_target  in  32  redirect PC; valid from the 2nd cycle of flush_req high
- flush_ack  out  1  flush acknowledge to the initiator
- stage_flush  out  NUM_STAGES  per-stage flush/hold; all bits equal
- stage_idle  in  NUM_STAGES  per-stage "empty, no in-flight op" indication
- fetch_redirect  out  1  one-cycle fetch redirect strobe
- fetch_target  out  32  redirect address; valid while fetch_redirect is 1
- flush_busy  out  1  high in any state other than IDLE
- flush_count  out  32  completed flush count; wraps modulo 2^32

Behaviour:
- One clock, clk_core. Reset is synchronous and active-high (rst_core), sampled on the rising edge of clk_core.
- All outputs are Moore outputs decoded from registered state; no combinational path from any input to any output.
- Reset, including mid-operation:
  - state goes to IDLE; cnt goes to 0.
  - flush_ack=0, stage_flush=0, fetch_redirect=0, flush_busy=0, fetch_target=0, flush_count=0.
  - If reset arrives mid-sequence, flush_ack drops in the cycle after the reset edge.
- States: IDLE, DRAIN, REDIRECT, ACK, RELEASE.
- IDLE:
  - All outputs 0.
  - flush_req=1 sampled: go to DRAIN and load cnt=MIN_FLUSH_CYCLES-1.
- DRAIN:
  - stage_flush all ones.
  - If cnt is nonzero, decrement it each cycle.
  - Exit to REDIRECT when cnt==0 and &stage_idle, both sampled in the same cycle.
  - On that exit edge, capture flush_target into the target register. The target is therefore sampled at least one cycle after flush_req rose, covering the initiator's registered flush_target.
  - stage_idle toggling during DRAIN only delays the exit; there is no timeout.
- REDIRECT:
  - Lasts exactly one cycle.
  - fetch_redirect=1, fetch_target=captured target, stage_flush=1.
  - Go to ACK.
- ACK:
  - flush_ack=1, stage_flush=1.
  - flush_count increments once, on the REDIRECT->ACK edge.
  - Remain in ACK while flush_req=1; there is no bound.
  - flush_req=0: go to RELEASE.
- RELEASE:
  - flush_ack=0, stage_flush=0.
  - flush_req is ignored.
  - Lasts one cycle, then go to IDLE.
  - A new flush_req is accepted from IDLE at the earliest.
- Protocol violation, flush_req dropping before ack:
  - The sequence still completes: DRAIN -> REDIRECT -> ACK.
  - ACK then sees flush_req=0, so flush_ack is high for exactly one cycle before RELEASE.
- fetch_target holds its last value outside REDIRECT.
- Latency: flush_req rises in cycle N.
  - stage_flush=1 at N+1.
  - Earliest fetch_redirect at N+MIN_FLUSH_CYCLES+1.
  - Earliest flush_ack at N+MIN_FLUSH_CYCLES+2.
- MIN_FLUSH_CYCLES counter width is clog2(MIN_FLUSH_CYCLES+1). Elaboration error if MIN_FLUSH_CYCLES<1.

Test Plan:
- Basic handshake (MIN=2, stage_idle all ones, flush_req high at cycle 0, flush_target=0x0000_0100 from cycle 1; drop flush_req 2 cycles after flush_ack rises):
  - stage_flush=1 at cycles 1-2.
  - fetch_redirect=1 with fetch_target=0x100 at cycle 3.
  - flush_ack=1 from cycle 4 until flush_req drops.
  - flush_ack=0 one cycle later.
  - flush_count=1.
- Slow drain (stage_idle=4'b0111 until cycle 10, then 4'b1111) -> fetch_redirect at cycle 11; stage_flush held 1 throughout.
- Long hold (flush_req held 100 cycles after ack) -> flush_ack and stage_flush stay 1 for the full hold; no second fetch_redirect; flush_count increments once.
- Back-to-back (flush_req re-raised the first cycle flush_ack is seen low) -> second flush accepted from IDLE; flush_count=2; second fetch_target = second flush_target value.
- Reset in ACK (rst_core=1 for one cycle) -> next cycle flush_ack=0, stage_flush=0, flush_count=0, flush_busy=0.
- Early req drop (flush_req low in the cycle after DRAIN entry) -> REDIRECT still occurs; flush_ack high exactly one cycle; then IDLE.
